// File: rtl/RS5_pkg.sv
// Shared definitions for the console UART transmitter.
//   - Register offsets as seen on addr_i (word aligned, 4-bit offset).
//   - Serializer state encoding.
//   - Helper that packs the STATUS register word.
package RS5_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_DIV    = 4'h8;
  localparam logic [3:0] UART_CTRL   = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  // STATUS layout: [0] full, [1] empty, [2] busy, [3] overflow, [15:8] count.
  function automatic logic [31:0] uart_status_word(input logic       full,
                                                   input logic       empty,
                                                   input logic       busy,
                                                   input logic       overflow,
                                                   input logic [7:0] count);
    return {16'h0000, count, 4'h0, overflow, busy, empty, full};
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO holding bytes waiting for the serializer.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   push, wdata        write request and data; ignored when full
//   pop                read request; ignored when empty
//   rdata              head of the FIFO (valid while not empty)
//   full, empty, count occupancy flags and entry count
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  // A pop on an empty FIFO is blocked, so a push into an empty FIFO proceeds alone.
  assign do_pop  = pop & ~empty;
  // The serializer loads the head in the same cycle it pops, so the head is read directly.
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 transmit UART for console output.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   en_i     peripheral select, one-cycle access
//   we_i     byte write enables; any bit set makes the access a write
//   addr_i   register offset (TXDATA 0x0, STATUS 0x4, DIV 0x8, CTRL 0xC)
//   data_i   write data
//   data_o   registered read data, valid the cycle after the access
//   tx_o     serial line, idle high
//   irq_o    level interrupt: enabled, FIFO empty and serializer idle
module uart_tx_periph
  import RS5_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en_i,
  input  logic [3:0]  we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Register file
  logic [15:0] div_reg;
  logic        tx_en_reg;
  logic        irq_en_reg;
  logic        ovf_reg;
  logic [31:0] data_reg;
  logic        irq_reg;

  // FIFO interface
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // Serializer
  uart_tx_state_e state_reg, state_next;
  logic [15:0]    timer_reg, timer_next;
  logic [15:0]    period_reg, period_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     shift_reg, shift_next;
  logic           tx_reg, tx_next;

  logic        wr_en;
  logic        busy;
  logic [31:0] rd_data;
  logic        unused_data;

  assign wr_en       = en_i & (|we_i);
  assign fifo_push   = wr_en & (addr_i == UART_TXDATA);
  assign busy        = (state_reg != IDLE);
  assign unused_data = &{1'b0, data_i[31:16]};

  uart_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (fifo_push),
    .wdata  (data_i[7:0]),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    rd_data = 32'h0;
    case (addr_i)
      UART_STATUS: rd_data = uart_status_word(fifo_full, fifo_empty, busy, ovf_reg,
                                              8'(fifo_count));
      UART_DIV:    rd_data = {16'h0000, div_reg};
      UART_CTRL:   rd_data = {30'h0, irq_en_reg, tx_en_reg};
      default:     rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg    <= DIV_RESET;
      tx_en_reg  <= 1'b1;
      irq_en_reg <= 1'b0;
      ovf_reg    <= 1'b0;
      data_reg   <= 32'h0;
      irq_reg    <= 1'b0;
    end else begin
      if (en_i) begin
        data_reg <= rd_data;
      end
      if (wr_en && (addr_i == UART_DIV)) begin
        div_reg <= data_i[15:0];
      end
      if (wr_en && (addr_i == UART_CTRL)) begin
        tx_en_reg  <= data_i[0];
        irq_en_reg <= data_i[1];
      end
      // A dropped byte is remembered until software writes STATUS.
      if (fifo_push && fifo_full) begin
        ovf_reg <= 1'b1;
      end else if (wr_en && (addr_i == UART_STATUS)) begin
        ovf_reg <= 1'b0;
      end
      irq_reg <= irq_en_reg & fifo_empty & ~busy;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      timer_reg   <= 16'h0;
      period_reg  <= 16'h0;
      bit_cnt_reg <= 3'h0;
      shift_reg   <= 8'h0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      period_reg  <= period_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  // Each bit lasts period_reg+1 cycles: the timer counts 0..period_reg.
  // tx_next is the value the line takes in the state being entered.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    period_next  = period_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    fifo_pop     = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_en_reg && !fifo_empty) begin
          // DIV is latched here so later writes only affect the next frame.
          fifo_pop    = 1'b1;
          shift_next  = fifo_rdata;
          period_next = div_reg;
          timer_next  = 16'h0;
          tx_next     = 1'b0;
          state_next  = START;
        end
      end
      START: begin
        if (timer_reg == period_reg) begin
          timer_next   = 16'h0;
          tx_next      = shift_reg[0];
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_cnt_next = 3'h0;
          state_next   = DATA;
        end else begin
          timer_next = timer_reg + 16'h1;
        end
      end
      DATA: begin
        if (timer_reg == period_reg) begin
          timer_next = 16'h0;
          if (bit_cnt_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'h1;
            tx_next      = shift_reg[0];
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end else begin
          timer_next = timer_reg + 16'h1;
        end
      end
      STOP: begin
        if (timer_reg == period_reg) begin
          timer_next = 16'h0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 16'h1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign data_o = data_reg;
  assign tx_o   = tx_reg;
  assign irq_o  = irq_reg;

endmodule
